// File: rtl/lpc_pkg.sv
// Shared LPC codec definitions: default frame geometry and control FSM state encoding.
// Used by both the decoder control and the encoder control.
package lpc_pkg;

    localparam int unsigned LPC_ORDER      = 10;
    localparam int unsigned LPC_MAX_FRAMES = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_START_SF = 3'd2,
        ST_RUN      = 3'd3,
        ST_NEXT     = 3'd4,
        ST_DONE     = 3'd5
    } lpc_state_e;

endpackage

// File: rtl/lpc_decode_control.sv
// LPC decoder sequencer: per frame, streams ORDER coefficients into the synthesis
// filter register file, kicks the filter, waits for completion, then advances.
module lpc_decode_control
    import lpc_pkg::*;
#(
    parameter int unsigned ORDER      = LPC_ORDER,
    parameter int unsigned MAX_FRAMES = LPC_MAX_FRAMES
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic [$clog2(MAX_FRAMES):0]         frames,
    input  logic                                ready_sfilter,
    output logic [$clog2(ORDER*MAX_FRAMES)-1:0] coef_raddr,
    output logic                                coef_load,
    output logic [4:0]                          coef_waddr,
    output logic                                reset_sfilter,
    output logic                                mem_sel,
    output logic [$clog2(MAX_FRAMES)-1:0]       frame_idx,
    output logic                                busy,
    output logic                                done
);

    localparam int unsigned FW  = $clog2(MAX_FRAMES);
    localparam int unsigned FRW = FW + 1;
    localparam int unsigned AW  = $clog2(ORDER * MAX_FRAMES);
    localparam int unsigned KW  = $clog2(ORDER + 1);

    lpc_state_e      state, state_n;
    logic [KW-1:0]   k, k_n;
    logic [FW-1:0]   frame_idx_n;
    logic [FRW-1:0]  nframes, nframes_n;
    logic [AW-1:0]   base, base_n;
    logic            last_frame;

    logic [AW-1:0]   coef_raddr_n;
    logic            coef_load_n;
    logic [4:0]      coef_waddr_n;
    logic            reset_sfilter_n;
    logic            mem_sel_n;
    logic            busy_n;
    logic            done_n;

    assign last_frame = ({1'b0, frame_idx} == nframes - FRW'(1));

    // Next-state logic; base tracks frame_idx*ORDER so no multiplier is needed.
    always_comb begin
        state_n     = state;
        k_n         = k;
        frame_idx_n = frame_idx;
        nframes_n   = nframes;
        base_n      = base;

        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n     = ST_LOAD;
                    k_n         = '0;
                    frame_idx_n = '0;
                    base_n      = '0;
                    if (frames == '0)
                        nframes_n = FRW'(1);
                    else if (frames > FRW'(MAX_FRAMES))
                        nframes_n = FRW'(MAX_FRAMES);
                    else
                        nframes_n = frames;
                end
            end
            ST_LOAD: begin
                if (k == KW'(ORDER))
                    state_n = ST_START_SF;
                else
                    k_n = k + KW'(1);
            end
            ST_START_SF: state_n = ST_RUN;
            ST_RUN: begin
                if (ready_sfilter)
                    state_n = last_frame ? ST_DONE : ST_NEXT;
            end
            ST_NEXT: begin
                state_n     = ST_LOAD;
                k_n         = '0;
                frame_idx_n = frame_idx + FW'(1);
                base_n      = base + AW'(ORDER);
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Output values for the coming cycle, decoded from next state only.
    always_comb begin
        coef_raddr_n    = '0;
        coef_load_n     = 1'b0;
        coef_waddr_n    = '0;
        reset_sfilter_n = (state_n == ST_START_SF);
        mem_sel_n       = (state_n == ST_START_SF) || (state_n == ST_RUN) || (state_n == ST_NEXT);
        busy_n          = (state_n != ST_IDLE);
        done_n          = (state_n == ST_DONE);
        if (state_n == ST_LOAD) begin
            if (k_n < KW'(ORDER))
                coef_raddr_n = base_n + AW'(k_n);
            // Write lags read by one cycle to cover the memory read latency.
            if (k_n != '0) begin
                coef_load_n  = 1'b1;
                coef_waddr_n = 5'(k_n - KW'(1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            k             <= '0;
            frame_idx     <= '0;
            nframes       <= '0;
            base          <= '0;
            coef_raddr    <= '0;
            coef_load     <= 1'b0;
            coef_waddr    <= '0;
            reset_sfilter <= 1'b0;
            mem_sel       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_n;
            k             <= k_n;
            frame_idx     <= frame_idx_n;
            nframes       <= nframes_n;
            base          <= base_n;
            coef_raddr    <= coef_raddr_n;
            coef_load     <= coef_load_n;
            coef_waddr    <= coef_waddr_n;
            reset_sfilter <= reset_sfilter_n;
            mem_sel       <= mem_sel_n;
            busy          <= busy_n;
            done          <= done_n;
        end
    end

endmodule

// File: tb/tb_lpc_decode_control.sv
// Bench for lpc_decode_control: cycle-level timeline model of a decode run,
// directed scenarios with literal expectations, then randomized traffic.
module tb_lpc_decode_control;

    localparam int ORD  = 10;
    localparam int MAXF = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [4:0] frames = 5'd0;
    logic       ready_sfilter = 1'b0;
    logic [7:0] coef_raddr;
    logic       coef_load;
    logic [4:0] coef_waddr;
    logic       reset_sfilter;
    logic       mem_sel;
    logic [3:0] frame_idx;
    logic       busy;
    logic       done;

    lpc_decode_control dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .frames        (frames),
        .ready_sfilter (ready_sfilter),
        .coef_raddr    (coef_raddr),
        .coef_load     (coef_load),
        .coef_waddr    (coef_waddr),
        .reset_sfilter (reset_sfilter),
        .mem_sel       (mem_sel),
        .frame_idx     (frame_idx),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Timeline model: a run is a sequence of frames; within a frame, m_c counts
    // cycles from the first LOAD cycle (0..ORD load, ORD+1 kick, then RUN cycles).
    bit m_act = 0, m_end = 0, m_last = 0;
    int m_F = 0, m_f = 0, m_c = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_act = 0; m_end = 0; m_f = 0; m_c = 0; m_F = 0;
        end else if (!m_act) begin
            if (start) begin
                m_act = 1; m_end = 0; m_f = 0; m_c = 0;
                m_F = (int'(frames) == 0) ? 1 : ((int'(frames) > MAXF) ? MAXF : int'(frames));
            end
        end else if (m_end) begin
            if (m_last) m_act = 0;
            else begin m_f++; m_c = 0; end
            m_end = 0;
        end else begin
            if (m_c >= ORD + 2 && ready_sfilter) begin
                m_end = 1;
                m_last = (m_f == m_F - 1);
            end
            m_c++;
        end
    end

    int rsf_cnt, done_cnt, load_cnt, waddr_sum, ld_raddr_sum, ld_cyc;
    int q_sr[$];
    int q_sf[$];

    task automatic clear_mon();
        rsf_cnt = 0; done_cnt = 0; load_cnt = 0; waddr_sum = 0;
        ld_raddr_sum = 0; ld_cyc = 0;
        q_sr = {}; q_sf = {};
    endtask

    // Per-cycle compare against the model, plus event tallies for directed checks.
    always @(negedge clk) begin
        int e_busy, e_done, e_mem, e_rsf, e_load, e_waddr, e_raddr;
        if (chk_en) begin
            e_busy  = m_act ? 1 : 0;
            e_done  = (m_act && m_end && m_last) ? 1 : 0;
            e_mem   = (m_act && m_c >= ORD + 1 && !(m_end && m_last)) ? 1 : 0;
            e_rsf   = (m_act && m_c == ORD + 1) ? 1 : 0;
            e_load  = (m_act && m_c >= 1 && m_c <= ORD) ? 1 : 0;
            e_waddr = e_load ? m_c - 1 : 0;
            e_raddr = (m_act && m_c < ORD) ? m_f * ORD + m_c : 0;
            chk("busy",          int'(busy),          e_busy);
            chk("done",          int'(done),          e_done);
            chk("mem_sel",       int'(mem_sel),       e_mem);
            chk("reset_sfilter", int'(reset_sfilter), e_rsf);
            chk("coef_load",     int'(coef_load),     e_load);
            chk("coef_waddr",    int'(coef_waddr),    e_waddr);
            chk("coef_raddr",    int'(coef_raddr),    e_raddr);
            chk("frame_idx",     int'(frame_idx),     m_f);

            if (reset_sfilter) rsf_cnt++;
            if (done) done_cnt++;
            if (coef_load) begin load_cnt++; waddr_sum += int'(coef_waddr); end
            if (busy && !mem_sel && !done) begin
                ld_cyc++;
                ld_raddr_sum += int'(coef_raddr);
                if (!coef_load) begin
                    q_sr.push_back(int'(coef_raddr));
                    q_sf.push_back(int'(frame_idx));
                end
            end
        end
    end

    // Filter completion: random, or on RUN cycle index rdy_d with noise outside RUN.
    int rdy_mode = 0;
    int rdy_d = 0;
    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_mode == 0)
            ready_sfilter = ($urandom_range(0, 3) == 0);
        else if (m_act && !m_end && m_c >= ORD + 2)
            ready_sfilter = (m_c - (ORD + 2) == rdy_d);
        else
            ready_sfilter = ($urandom_range(0, 1) == 1);
    end

    task automatic run(input int fr, input int d, input bit hold, output int done_edge);
        rdy_mode = 1; rdy_d = d;
        frames = 5'(fr);
        start = 1'b1;
        clear_mon();
        done_edge = -1;
        for (int e = 1; e <= 3000 && done_edge < 0; e++) begin
            @(posedge clk); #2;
            if (!hold) start = 1'b0;
            if (done === 1'b1) done_edge = e;
        end
        if (done_edge < 0) chk("run_timeout", 0, 1);
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    initial begin
        int de;
        int gap;
        bit found;

        repeat (3) @(posedge clk);
        #2; chk_en = 1;
        @(posedge clk); #2;
        chk("rst_busy", int'(busy), 0);
        chk("rst_mem_sel", int'(mem_sel), 0);
        chk("rst_raddr", int'(coef_raddr), 0);
        chk("rst_frame_idx", int'(frame_idx), 0);
        reset = 1'b0;
        @(posedge clk); #2;

        // Single frame, filter completes on RUN cycle 20.
        run(1, 20, 0, de);
        @(posedge clk); #2;
        chk("t1_done_edge", de, 34);
        chk("t1_load_cnt", load_cnt, 10);
        chk("t1_waddr_sum", waddr_sum, 45);
        chk("t1_raddr_sum", ld_raddr_sum, 45);
        chk("t1_load_cycles", ld_cyc, 11);
        chk("t1_rsf_cnt", rsf_cnt, 1);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_first_raddr", qget(q_sr, 0), 0);

        // Three frames.
        run(3, 3, 0, de);
        @(posedge clk); #2;
        chk("t2_done_edge", de, 51);
        chk("t2_frames", q_sr.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("t2_start_raddr", qget(q_sr, i), 10 * i);
            chk("t2_frame_idx", qget(q_sf, i), i);
        end
        chk("t2_rsf_cnt", rsf_cnt, 3);
        chk("t2_done_cnt", done_cnt, 1);
        chk("t2_load_cnt", load_cnt, 30);

        // Zero frames behaves as one.
        run(0, 20, 0, de);
        @(posedge clk); #2;
        chk("t3_done_edge", de, 34);
        chk("t3_frames", q_sr.size(), 1);
        chk("t3_rsf_cnt", rsf_cnt, 1);

        // start held high: one IDLE cycle between runs.
        run(1, 2, 1, de);
        gap = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #2;
            if (busy) break;
            gap++;
        end
        chk("t4_idle_gap", gap, 1);
        chk("t4_done_cnt", done_cnt, 1);
        start = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #2;
            if (done) break;
        end
        @(posedge clk); #2;
        chk("t4_done_cnt2", done_cnt, 2);

        // Reset during RUN of frame 1 of 3.
        rdy_d = 5; frames = 5'd3; start = 1'b1;
        @(posedge clk); #2; start = 1'b0;
        found = 0;
        for (int i = 0; i < 500 && !found; i++) begin
            if (m_act && m_f == 1 && !m_end && m_c >= ORD + 2) found = 1;
            else begin @(posedge clk); #2; end
        end
        chk("t5_reach_run", int'(found), 1);
        reset = 1'b1;
        clear_mon();
        @(posedge clk); #2;
        reset = 1'b0;
        chk("t5_busy", int'(busy), 0);
        chk("t5_mem_sel", int'(mem_sel), 0);
        chk("t5_frame_idx", int'(frame_idx), 0);
        repeat (40) begin @(posedge clk); #2; end
        chk("t5_no_done", done_cnt, 0);
        run(3, 1, 0, de);
        @(posedge clk); #2;
        chk("t5_done_edge", de, 45);
        chk("t5_first_raddr", qget(q_sr, 0), 0);
        chk("t5_first_frame", qget(q_sf, 0), 0);

        // frames above MAX_FRAMES saturates.
        run(20, 0, 0, de);
        @(posedge clk); #2;
        chk("t6_done_edge", de, 224);
        chk("t6_frames", q_sr.size(), 16);
        chk("t6_last_raddr", qget(q_sr, 15), 150);
        chk("t6_last_frame", qget(q_sf, 15), 15);

        // Randomized traffic.
        rdy_mode = 0;
        for (int i = 0; i < 8000; i++) begin
            @(posedge clk); #2;
            start  = ($urandom_range(0, 2) == 0);
            frames = 5'($urandom);
            reset  = ($urandom_range(0, 199) == 0);
        end
        start = 1'b0; reset = 1'b0;
        repeat (400) begin @(posedge clk); #2; end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
